block_mem_responder: RTL and testbench
======================================

Name: block_mem_responder

Overview:
- Main-memory model that answers the 256-bit block read and write requests issued by the pipeline's data-side cache interface (dBlkRead/dBlkWrite with block_read_fDM_valid/block_write_fDM_valid).
- Serves requests one at a time, with a fixed, configurable latency. Owns a block-addressed backing store.
- Instantiated in the simulation top next to MIPS. It is the responder end of the block interface that MIPS drives as initiator.

Parameters:
- LATENCY, 8, cycles from request acceptance to the valid pulse; legal range 1..255.
- DEPTH_LOG2, 10, log2 of the number of 32-byte blocks in the backing store.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- block_address_IN  in  32  byte address of the request; bits [4:0] are ignored.
- BlkRead_IN  in  1  block read request; held high by the initiator until the read valid pulse.
- BlkWrite_IN  in  1  block write request; held high by the initiator until the write valid pulse.
- block_write_IN  in  256  write data, sampled at acceptance.
- block_read_OUT  out  256  read data.
- block_read_valid_OUT  out  1  one-cycle pulse that completes a read.
- block_write_valid_OUT  out  1  one-cycle pulse that completes a write.
- busy_OUT  out  1  high while a request is in flight.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all outputs 0; latency counter 0.
  - Backing store is not cleared.
  - Reset mid-transaction aborts the transaction. No valid pulse is issued and the store is not written.
- Block index = block_address_IN[DEPTH_LOG2+4:5]. Higher address bits are ignored, so addresses wrap modulo the store size.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if BlkWrite_IN is high, accept a write. Otherwise, if BlkRead_IN is high, accept a read.
  - Acceptance latches the op, the block index and (for writes) block_write_IN, then moves to BUSY with counter = LATENCY-1. busy_OUT goes high in the cycle after acceptance.
  - BUSY: counter decrements each cycle. When counter == 0, move to RESP. Inputs are ignored while in BUSY.
  - RESP, read: block_read_valid_OUT = 1 for exactly this cycle. block_read_OUT = store[index], registered and updated on entry to RESP.
  - RESP, write: block_write_valid_OUT = 1 for exactly this cycle. The store is written at the clock edge that ends RESP.
  - RESP always returns to IDLE. busy_OUT = 0 in the following cycle.
- Latency: a request accepted at the edge ending cycle t produces its valid pulse in cycle t+LATENCY.
  - LATENCY=1 goes straight from acceptance to RESP; BUSY is skipped.
- block_read_OUT holds the last read data until the next read reaches RESP. It is unaffected by writes.
- Initiator rule: the request must be deasserted in the cycle after its valid pulse. A request still high in IDLE is treated as a new request.
- Simultaneous BlkRead_IN and BlkWrite_IN in IDLE:
  - The write is served first. The read stays pending, because the initiator is still holding it.
  - The read is accepted in the IDLE cycle after the write's RESP, so it sees the newly written data. This matches a victim write-back followed by a refill.
- The two valid outputs are never high in the same cycle. Every cycle that is not RESP has both valids at 0.

Optional Feature:
- Macro: BLOCK_MEM_STATS_EN.
- Defined:
  - Adds outputs read_count_OUT[31:0] and write_count_OUT[31:0].
  - Each counter increments once per completed RESP of its type and wraps at 2^32.
  - Both counters clear on RESET.
- Undefined: the ports and counters do not exist, and the rest of the behaviour is unchanged.

Decomposition:
- Shared package holds:
  - BLOCK_BITS=256 and BLOCK_OFFSET_BITS=5;
  - the state enum (IDLE/BUSY/RESP);
  - the op enum (OP_READ/OP_WRITE).
- One natural sub-module is block_mem_array: a single-port 256-bit-wide synchronous store of 2^DEPTH_LOG2 entries, with one read or one write per cycle. The FSM and the latency counter stay in the top module.

Test Plan:
- Read latency/pulse: with LATENCY=8 and the store preloaded with block 3 = 0xA5..A5, hold BlkRead_IN with address 0x60 -> exactly one block_read_valid_OUT pulse, 8 cycles after acceptance, with block_read_OUT = 0xA5..A5 held afterwards.
- Write then read: write 0x1234..(pattern) to address 0x400, then read 0x41F (offset bits ignored) -> read returns the pattern; block_write_valid_OUT pulses once with LATENCY=8.
- Simultaneous: BlkRead_IN and BlkWrite_IN raised together, both at address 0x80 -> write pulse first, read pulse LATENCY+1 cycles later returning the written data; the two valids are never both high.
- Wrap: with DEPTH_LOG2=10, write to 0x8000 -> a read of 0x0 returns the same data.
- Reset mid-op: assert RESET 3 cycles into a write -> no valid pulse, busy_OUT=0, the old block contents are unchanged on a subsequent read.
- LATENCY=1 plus stats (BLOCK_MEM_STATS_EN): 5 back-to-back reads and 2 writes -> each valid arrives 1 cycle after acceptance; read_count_OUT=5 and write_count_OUT=2; both counters read 0 after RESET.

Source files
------------

// File: rtl/block_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// block_mem_responder_pkg
// Shared types and constants for the block memory responder: block geometry,
// FSM state encoding and the request operation type.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package block_mem_responder_pkg;

  // One block is 32 bytes = 256 bits; the low 5 address bits select a byte
  // inside the block and are ignored by the responder.
  localparam int BLOCK_BITS        = 256;
  localparam int BLOCK_OFFSET_BITS = 5;

  // Width of the block number carried by a 32-bit byte address.
  localparam int BLOCK_NUM_BITS    = 32 - BLOCK_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Strip the in-block byte offset from a byte address.
  function automatic logic [BLOCK_NUM_BITS-1:0] block_number(input logic [31:0] addr);
    return addr[31:BLOCK_OFFSET_BITS];
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_mem_responder_if.sv
// ---------------------------------------------------------------------------
// block_mem_responder_if
// Block read/write request bus between the data-side cache (initiator,
// master modport) and the main-memory model (responder, slave modport).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface block_mem_responder_if;
  import block_mem_responder_pkg::*;

  logic [31:0]           block_address_IN;
  logic                  BlkRead_IN;
  logic                  BlkWrite_IN;
  logic [BLOCK_BITS-1:0] block_write_IN;
  logic [BLOCK_BITS-1:0] block_read_OUT;
  logic                  block_read_valid_OUT;
  logic                  block_write_valid_OUT;
  logic                  busy_OUT;

  // Cache side: issues requests and holds them until the matching valid.
  modport master (
    output block_address_IN,
    output BlkRead_IN,
    output BlkWrite_IN,
    output block_write_IN,
    input  block_read_OUT,
    input  block_read_valid_OUT,
    input  block_write_valid_OUT,
    input  busy_OUT
  );

  // Memory side: accepts one request at a time and answers it.
  modport slave (
    input  block_address_IN,
    input  BlkRead_IN,
    input  BlkWrite_IN,
    input  block_write_IN,
    output block_read_OUT,
    output block_read_valid_OUT,
    output block_write_valid_OUT,
    output busy_OUT
  );

endinterface

`default_nettype wire

// File: rtl/block_mem_responder_array.sv
// ---------------------------------------------------------------------------
// block_mem_array
// Single-port synchronous block store: 2^DEPTH_LOG2 entries of WIDTH bits,
// one read or one write per cycle. Read data is registered and holds its
// value until the next read. Contents are not affected by reset.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module block_mem_array
  import block_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = BLOCK_BITS
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  input  wire logic                  re_i,
  input  wire logic                  we_i,
  input  wire logic [DEPTH_LOG2-1:0] addr_i,
  input  wire logic [WIDTH-1:0]      wdata_i,
  output logic      [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rdata_q;

  // Storage write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port; a write in the same cycle takes the port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/block_mem_responder.sv
// ---------------------------------------------------------------------------
// block_mem_responder
// Main-memory model answering 256-bit block reads/writes with a fixed
// LATENCY (1..255) from acceptance to the one-cycle valid pulse. Requests
// are served one at a time; a write wins over a simultaneous read, and the
// still-held read is accepted in the idle cycle after the write completes.
// Optional: define BLOCK_MEM_STATS_EN to add read/write completion counters.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module block_mem_responder
  import block_mem_responder_pkg::*;
#(
  parameter int LATENCY    = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input wire logic              CLK,
  input wire logic              RESET,
  block_mem_responder_if.slave  bus
`ifdef BLOCK_MEM_STATS_EN
  ,
  output logic [31:0]           read_count_OUT,
  output logic [31:0]           write_count_OUT
`endif
);

  // Counter preload: the BUSY phase lasts LATENCY-1 cycles, RESP is the last.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  op_e                     op_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [BLOCK_BITS-1:0]   wdata_q;

  logic                    accept;
  op_e                     accept_op;
  logic                    mem_re;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_addr;
  logic [DEPTH_LOG2-1:0]   in_idx;
  logic [BLOCK_NUM_BITS-1:0] blk_num;
  logic [BLOCK_BITS-1:0]   rd_data;
  logic                    unused_addr_bits;

  // Address bits above the store depth wrap; bits [4:0] select a byte.
  assign blk_num          = block_number(bus.block_address_IN);
  assign in_idx           = blk_num[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^{blk_num, bus.block_address_IN[BLOCK_OFFSET_BITS-1:0]};

  // Next-state, acceptance and store-port control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    accept_op = OP_READ;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.BlkWrite_IN) begin
          accept    = 1'b1;
          accept_op = OP_WRITE;
        end else if (bus.BlkRead_IN) begin
          accept    = 1'b1;
          accept_op = OP_READ;
        end
        if (accept) begin
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            // No BUSY phase: fetch now so data is ready on entry to RESP.
            state_d = RESP;
            mem_re  = (accept_op == OP_READ);
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          // Final BUSY cycle: read the store so block_read_OUT updates as
          // the FSM enters RESP.
          state_d = RESP;
          mem_re  = (op_q == OP_READ);
        end
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = (op_q == OP_WRITE);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q  <= accept_op;
        idx_q <= in_idx;
        if (accept_op == OP_WRITE) begin
          wdata_q <= bus.block_write_IN;
        end
      end
    end
  end

  // In IDLE the store sees the live address (LATENCY=1 fetch); otherwise
  // the latched block index of the request in flight.
  assign mem_addr = (state_q == IDLE) ? in_idx : idx_q;

  block_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (BLOCK_BITS)
  ) u_array (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .re_i    (mem_re),
    .we_i    (mem_we && !RESET),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (rd_data)
  );

  assign bus.block_read_OUT        = rd_data;
  assign bus.block_read_valid_OUT  = (state_q == RESP) && (op_q == OP_READ);
  assign bus.block_write_valid_OUT = (state_q == RESP) && (op_q == OP_WRITE);
  assign bus.busy_OUT              = (state_q != IDLE);

`ifdef BLOCK_MEM_STATS_EN
  logic [31:0] read_count_q;
  logic [31:0] write_count_q;

  // Completion counters: one count per finished RESP, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else if (state_q == RESP) begin
      if (op_q == OP_READ) begin
        read_count_q <= read_count_q + 32'd1;
      end else begin
        write_count_q <= write_count_q + 32'd1;
      end
    end
  end

  assign read_count_OUT  = read_count_q;
  assign write_count_OUT = write_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_block_mem_responder
// Drives two responders (LATENCY=8 and LATENCY=1) from one request source
// and compares every response cycle against a reference model of the block
// store, the latency rule and the completion counts.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_block_mem_responder;

  localparam int DL = 10;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         sel = 1'b0;
  logic         drv_rd = 1'b0;
  logic         drv_wr = 1'b0;
  logic [31:0]  drv_addr = '0;
  logic [255:0] drv_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  block_mem_responder_if if8 ();
  block_mem_responder_if if1 ();

  assign if8.BlkRead_IN       = drv_rd & ~sel;
  assign if8.BlkWrite_IN      = drv_wr & ~sel;
  assign if8.block_address_IN = drv_addr;
  assign if8.block_write_IN   = drv_data;
  assign if1.BlkRead_IN       = drv_rd & sel;
  assign if1.BlkWrite_IN      = drv_wr & sel;
  assign if1.block_address_IN = drv_addr;
  assign if1.block_write_IN   = drv_data;

`ifdef BLOCK_MEM_STATS_EN
  logic [31:0] rc8, wc8, rc1, wc1;
`endif

  block_mem_responder #(.LATENCY(8), .DEPTH_LOG2(DL)) u_dut8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if8)
`ifdef BLOCK_MEM_STATS_EN
    ,
    .read_count_OUT  (rc8),
    .write_count_OUT (wc8)
`endif
  );

  block_mem_responder #(.LATENCY(1), .DEPTH_LOG2(DL)) u_dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if1)
`ifdef BLOCK_MEM_STATS_EN
    ,
    .read_count_OUT  (rc1),
    .write_count_OUT (wc1)
`endif
  );

  // Observed outputs of the currently selected DUT.
  wire [255:0] o_rdata = sel ? if1.block_read_OUT        : if8.block_read_OUT;
  wire         o_rv    = sel ? if1.block_read_valid_OUT  : if8.block_read_valid_OUT;
  wire         o_wv    = sel ? if1.block_write_valid_OUT : if8.block_write_valid_OUT;
  wire         o_busy  = sel ? if1.busy_OUT              : if8.busy_OUT;

  // Reference model: per-DUT block contents, last returned read, counts.
  logic [255:0] mdl [int];
  logic [255:0] last_rd [2];
  int unsigned  rd_cnt [2];
  int unsigned  wr_cnt [2];

  function automatic int key_of(input logic sel_i, input logic [31:0] addr);
    return (sel_i ? 4096 : 0) + int'((addr >> 5) % (1 << DL));
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model_outputs();
    last_rd[0] = '0; last_rd[1] = '0;
    rd_cnt[0] = 0; rd_cnt[1] = 0;
    wr_cnt[0] = 0; wr_cnt[1] = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 256'(o_busy), 256'(0));
    chk({tag, "_valid"}, 256'({o_rv, o_wv}), 256'(0));
    chk({tag, "_rdata"}, o_rdata, last_rd[sel]);
`ifdef BLOCK_MEM_STATS_EN
    chk({tag, "_rd_count"}, 256'(sel ? rc1 : rc8), 256'(rd_cnt[sel]));
    chk({tag, "_wr_count"}, 256'(sel ? wc1 : wc8), 256'(wr_cnt[sel]));
`endif
  endtask

  // Entered and left #1 after a rising edge. One full request: idle cycle,
  // acceptance edge, then LATENCY sampled cycles ending on the valid pulse.
  task automatic transact(input bit is_wr, input bit hold_rd,
                          input logic [31:0] addr, input logic [255:0] data);
    int lat;
    int key;
    lat = sel ? 1 : 8;
    key = key_of(sel, addr);
    drv_addr = addr;
    drv_data = data;
    drv_wr   = is_wr;
    drv_rd   = !is_wr || hold_rd;
    @(negedge CLK);
    check_idle("pre");
    @(posedge CLK);
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      chk("busy", 256'(o_busy), 256'(1));
      if (c < lat) begin
        chk("early_valid", 256'({o_rv, o_wv}), 256'(0));
        chk("rdata_busy", o_rdata, last_rd[sel]);
      end else if (is_wr) begin
        chk("wr_pulse", 256'({o_rv, o_wv}), 256'(2'b01));
      end else begin
        chk("rd_pulse", 256'({o_rv, o_wv}), 256'(2'b10));
        chk("rd_data", o_rdata, mdl[key]);
      end
    end
    if (is_wr) begin
      mdl[key] = data;
      wr_cnt[sel]++;
    end else begin
      last_rd[sel] = mdl[key];
      rd_cnt[sel]++;
    end
    @(posedge CLK);
    #1;
    drv_wr = 1'b0;
    if (!hold_rd) drv_rd = 1'b0;
  endtask

  // Write aborted by reset three cycles after acceptance (LATENCY=8 DUT).
  task automatic abort_write(input logic [31:0] addr, input logic [255:0] data);
    drv_addr = addr;
    drv_data = data;
    drv_wr   = 1'b1;
    @(negedge CLK);
    check_idle("abort_pre");
    @(posedge CLK);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      chk("abort_busy", 256'(o_busy), 256'(1));
      chk("abort_valid", 256'({o_rv, o_wv}), 256'(0));
    end
    @(posedge CLK);
    #1;
    RESET  = 1'b1;
    drv_wr = 1'b0;
    @(negedge CLK);
    chk("abort_rst_valid", 256'({o_rv, o_wv}), 256'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model_outputs();
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("abort_after_busy", 256'(o_busy), 256'(0));
      chk("abort_after_valid", 256'({o_rv, o_wv}), 256'(0));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic random_ops(input int n);
    int idxq[$];
    int idx;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      if (idxq.size() == 0 || $urandom_range(1) == 0) begin
        a = $urandom;
        idxq.push_back(int'((a >> 5) % (1 << DL)));
        transact(1'b1, 1'b0, a, rand256());
      end else begin
        idx = idxq[$urandom_range(idxq.size() - 1)];
        a = ($urandom & ~32'h0000_7FE0) | (32'(idx) << 5);
        transact(1'b0, 1'b0, a, '0);
      end
    end
  endtask

  logic [255:0] pat;

  initial begin
    clear_model_outputs();
    // Reset both responders and check the quiescent outputs.
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_idle("reset8");
    sel = 1'b1;
    #0;
    check_idle("reset1");
    sel = 1'b0;
    @(posedge CLK);
    #1;

    // Block 3 via address 0x60, read back with full latency.
    transact(1'b1, 1'b0, 32'h0000_0060, {32{8'hA5}});
    transact(1'b0, 1'b0, 32'h0000_0060, '0);

    // Offset bits ignored: write 0x400, read 0x41F.
    for (int i = 0; i < 16; i++) pat[i*16 +: 16] = 16'h1234 + 16'(i);
    transact(1'b1, 1'b0, 32'h0000_0400, pat);
    transact(1'b0, 1'b0, 32'h0000_041F, '0);

    // Simultaneous read+write at 0x80: write first, held read follows.
    transact(1'b1, 1'b1, 32'h0000_0080, ~pat);
    transact(1'b0, 1'b0, 32'h0000_0080, '0);

    // Address wrap modulo the store size.
    transact(1'b1, 1'b0, 32'h0000_8000, rand256());
    transact(1'b0, 1'b0, 32'h0000_0000, '0);

    // Reset three cycles into a write leaves block 3 untouched.
    abort_write(32'h0000_0060, 256'hDEAD_BEEF);
    transact(1'b0, 1'b0, 32'h0000_0060, '0);

    random_ops(12);

    // LATENCY=1 responder: two writes then five back-to-back reads.
    sel = 1'b1;
    @(posedge CLK);
    #1;
    transact(1'b1, 1'b0, 32'h0000_0100, pat);
    transact(1'b1, 1'b0, 32'h0000_0120, ~pat);
    for (int i = 0; i < 5; i++) begin
      transact(1'b0, 1'b0, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_013C, '0);
    end
    transact(1'b1, 1'b1, 32'h0000_0140, rand256());
    transact(1'b0, 1'b0, 32'h0000_0140, '0);
    random_ops(12);
    @(negedge CLK);
    check_idle("lat1_end");

    // Reset clears read data and counters; store contents survive.
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model_outputs();
    @(negedge CLK);
    check_idle("final_reset1");
    sel = 1'b0;
    #0;
    check_idle("final_reset8");
    @(posedge CLK);
    #1;
    sel = 1'b1;
    transact(1'b0, 1'b0, 32'h0000_0100, '0);
    @(negedge CLK);
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
